// File: rtl/des_pkg.sv
// Shared DES constants: permutation tables, key shift schedule, S-box contents
// and the FSM state encoding, with small helpers that apply each table.
package des_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam int N_ROUNDS = 16;

   // Bit r-1 set when round r rotates by two; the remaining rounds rotate by one.
   localparam logic [0:15] SHIFT_TWO = 16'b0011_1111_0111_1110;

   localparam int IP_T [0:63] = '{
      58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
      62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
      57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
      61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

   localparam int FP_T [0:63] = '{
      40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
      38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
      36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
      34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};

   localparam int E_T [0:47] = '{
      32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
       8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
      16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
      24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

   localparam int P_T [0:31] = '{
      16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
       2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

   localparam int PC1_T [0:55] = '{
      57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

   localparam int PC2_T [0:47] = '{
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

   // Entry (row*16 + col) sits in nibble order from the MSB end.
   localparam logic [255:0] SBOX_T [0:7] = '{
      256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
      256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
      256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
      256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
      256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
      256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
      256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
      256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

   function automatic logic [63:0] ip(input logic [63:0] x);
      logic [63:0] y;
      y = '0;
      for (int i = 0; i < 64; i++) y[63-i] = x[64-IP_T[i]];
      return y;
   endfunction

   function automatic logic [63:0] fp(input logic [63:0] x);
      logic [63:0] y;
      y = '0;
      for (int i = 0; i < 64; i++) y[63-i] = x[64-FP_T[i]];
      return y;
   endfunction

   function automatic logic [47:0] e_expand(input logic [31:0] x);
      logic [47:0] y;
      y = '0;
      for (int i = 0; i < 48; i++) y[47-i] = x[32-E_T[i]];
      return y;
   endfunction

   function automatic logic [31:0] p_perm(input logic [31:0] x);
      logic [31:0] y;
      y = '0;
      for (int i = 0; i < 32; i++) y[31-i] = x[32-P_T[i]];
      return y;
   endfunction

   function automatic logic [55:0] pc1(input logic [63:0] x);
      logic [55:0] y;
      y = '0;
      for (int i = 0; i < 56; i++) y[55-i] = x[64-PC1_T[i]];
      return y;
   endfunction

   function automatic logic [47:0] pc2(input logic [55:0] x);
      logic [47:0] y;
      y = '0;
      for (int i = 0; i < 48; i++) y[47-i] = x[56-PC2_T[i]];
      return y;
   endfunction

   function automatic logic [3:0] sbox(input int n, input logic [5:0] x);
      logic [7:0]   shamt;
      logic [255:0] t;
      shamt = {x[5], x[0], x[4:1], 2'b00};
      t     = SBOX_T[n] << shamt;
      return t[255:252];
   endfunction

endpackage

// File: rtl/des_round.sv
// DES round function f(R,K) = P(S(E(R) ^ K)); combinational, no state.
module des_round import des_pkg::*; (
   input  logic [31:0] r,
   input  logic [47:0] k,
   output logic [31:0] f
);
   logic [47:0] x;
   logic [31:0] s;

   assign x = e_expand(r) ^ k;

   des_s1 u_s1 (.b(x[47:42]), .s(s[31:28]));
   des_s2 u_s2 (.b(x[41:36]), .s(s[27:24]));
   des_s3 u_s3 (.b(x[35:30]), .s(s[23:20]));
   des_s4 u_s4 (.b(x[29:24]), .s(s[19:16]));
   des_s5 u_s5 (.b(x[23:18]), .s(s[15:12]));
   des_s6 u_s6 (.b(x[17:12]), .s(s[11:8]));
   des_s7 u_s7 (.b(x[11:6]),  .s(s[7:4]));
   des_s8 u_s8 (.b(x[5:0]),   .s(s[3:0]));

   assign f = p_perm(s);
endmodule

// File: rtl/des_sbox.sv
// DES substitution boxes S1..S8: 6-bit input, 4-bit output, purely combinational.
module des_s1 import des_pkg::*; (input logic [5:0] b, output logic [3:0] s);
   assign s = sbox(0, b);
endmodule

module des_s2 import des_pkg::*; (input logic [5:0] b, output logic [3:0] s);
   assign s = sbox(1, b);
endmodule

module des_s3 import des_pkg::*; (input logic [5:0] b, output logic [3:0] s);
   assign s = sbox(2, b);
endmodule

module des_s4 import des_pkg::*; (input logic [5:0] b, output logic [3:0] s);
   assign s = sbox(3, b);
endmodule

module des_s5 import des_pkg::*; (input logic [5:0] b, output logic [3:0] s);
   assign s = sbox(4, b);
endmodule

module des_s6 import des_pkg::*; (input logic [5:0] b, output logic [3:0] s);
   assign s = sbox(5, b);
endmodule

module des_s7 import des_pkg::*; (input logic [5:0] b, output logic [3:0] s);
   assign s = sbox(6, b);
endmodule

module des_s8 import des_pkg::*; (input logic [5:0] b, output logic [3:0] s);
   assign s = sbox(7, b);
endmodule

// File: rtl/des_iter_core.sv
// Iterative DES engine: one Feistel round per clock, 16 rounds per block,
// encrypt or decrypt selected per request.
//   state | meaning
//   IDLE  | ready for a request, in_ready high
//   RUN   | applying rounds 1..16, rnd_q = round number - 1
//   DONE  | out_data valid, held until out_ready
module des_iter_core import des_pkg::*; (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        in_decrypt,
   input  logic [63:0] in_key,
   input  logic [63:0] in_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] out_data
);
   state_t      state_q, state_d;
   logic [3:0]  rnd_q, rnd_d;
   logic [31:0] l_q, l_d, r_q, r_d;
   logic [27:0] c_q, c_d, d_q, d_d;
   logic        dec_q, dec_d;
   logic [63:0] out_q, out_d;

   logic [27:0] c_rot, d_rot;
   logic [3:0]  back_idx;
   logic [47:0] sub_k;
   logic [31:0] f_out;
   logic [63:0] ip_in;
   logic [55:0] pc1_key;

   // 0 - rnd_q wraps to 16 - rnd_q: decrypt walks the shift schedule backwards.
   assign back_idx = 4'd0 - rnd_q;

   always_comb begin
      c_rot = c_q;
      d_rot = d_q;
      if (!dec_q) begin
         if (SHIFT_TWO[rnd_q]) begin
            c_rot = {c_q[25:0], c_q[27:26]};
            d_rot = {d_q[25:0], d_q[27:26]};
         end else begin
            c_rot = {c_q[26:0], c_q[27]};
            d_rot = {d_q[26:0], d_q[27]};
         end
      end else if (rnd_q != 4'd0) begin
         if (SHIFT_TWO[back_idx]) begin
            c_rot = {c_q[1:0], c_q[27:2]};
            d_rot = {d_q[1:0], d_q[27:2]};
         end else begin
            c_rot = {c_q[0], c_q[27:1]};
            d_rot = {d_q[0], d_q[27:1]};
         end
      end
   end

   assign sub_k = pc2({c_rot, d_rot});

   des_round u_round (.r(r_q), .k(sub_k), .f(f_out));

   always_comb begin
      state_d = state_q;
      rnd_d   = rnd_q;
      l_d     = l_q;
      r_d     = r_q;
      c_d     = c_q;
      d_d     = d_q;
      dec_d   = dec_q;
      out_d   = out_q;
      ip_in   = ip(in_data);
      pc1_key = pc1(in_key);
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               l_d     = ip_in[63:32];
               r_d     = ip_in[31:0];
               c_d     = pc1_key[55:28];
               d_d     = pc1_key[27:0];
               dec_d   = in_decrypt;
               rnd_d   = 4'd0;
               state_d = RUN;
            end
         end
         RUN: begin
            l_d   = r_q;
            r_d   = l_q ^ f_out;
            c_d   = c_rot;
            d_d   = d_rot;
            rnd_d = rnd_q + 4'd1;
            if (rnd_q == 4'(N_ROUNDS - 1)) begin
               out_d   = fp({r_d, l_d});
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         rnd_q   <= '0;
         l_q     <= '0;
         r_q     <= '0;
         c_q     <= '0;
         d_q     <= '0;
         dec_q   <= 1'b0;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         rnd_q   <= rnd_d;
         l_q     <= l_d;
         r_q     <= r_d;
         c_q     <= c_d;
         d_q     <= d_d;
         dec_q   <= dec_d;
         out_q   <= out_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign out_data  = out_q;
endmodule

// File: tb/tb_des_iter_core.sv
// Self-checking bench for des_iter_core: known answers queued at accept and
// compared when each result is handed off.
module tb_des_iter_core;
   localparam logic [63:0] K1  = 64'h133457799BBCDFF1;
   localparam logic [63:0] P1  = 64'h0123456789ABCDEF;
   localparam logic [63:0] C1  = 64'h85E813540F0AB405;
   localparam logic [63:0] CZ  = 64'h8CA64DE9C1B123A7;
   localparam logic [63:0] WK  = 64'h0101010101010101;
   localparam logic [63:0] PAR = 64'h0101010101010101;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_decrypt = 1'b0;
   logic        out_ready = 1'b0;
   logic [63:0] in_key = '0;
   logic [63:0] in_data = '0;
   logic        in_ready, out_valid;
   logic [63:0] out_data;

   logic [63:0] exp_q[$];
   bit          chk_q[$];
   int          n_cmp = 0;
   int          n_err = 0;

   always #5 clk = ~clk;

   des_iter_core dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_decrypt(in_decrypt), .in_key(in_key), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
   );

   task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic send(input logic [63:0] key, input logic [63:0] data, input logic dec,
                       input logic [63:0] exp, input bit do_chk);
      int n = 0;
      in_key     = key;
      in_data    = data;
      in_decrypt = dec;
      in_valid   = 1'b1;
      while (!in_ready && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      if (!in_ready) chk_eq("accept_timeout", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      exp_q.push_back(exp);
      chk_q.push_back(do_chk);
   endtask

   task automatic receive(input string tag, input bit lat_chk, output logic [63:0] got);
      int          n = 0;
      logic [63:0] e;
      bit          c;
      out_ready = 1'b1;
      while (!out_valid && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      chk_eq({tag, "_valid"}, 64'(out_valid), 64'd1);
      if (lat_chk) chk_eq({tag, "_latency"}, 64'(n), 64'd16);
      got = out_data;
      e = exp_q.pop_front();
      c = chk_q.pop_front();
      if (c) chk_eq(tag, out_data, e);
      chk_eq({tag, "_no_bypass"}, 64'(in_ready), 64'd0);
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk_eq({tag, "_idle"}, 64'(in_ready), 64'd1);
   endtask

   initial begin
      logic [63:0] r;
      logic [63:0] held;
      int          n;

      repeat (2) @(posedge clk);
      #1;
      chk_eq("rst_in_ready", 64'(in_ready), 64'd1);
      chk_eq("rst_out_valid", 64'(out_valid), 64'd0);
      chk_eq("rst_out_data", out_data, 64'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      send(K1, P1, 1'b0, C1, 1'b1);  receive("kat_enc", 1'b1, r);
      send(K1, C1, 1'b1, P1, 1'b1);  receive("kat_dec", 1'b1, r);
      send(64'd0, 64'd0, 1'b0, CZ, 1'b1);  receive("zero_enc", 1'b1, r);
      send(64'd0, CZ, 1'b1, 64'd0, 1'b1);  receive("zero_dec", 1'b1, r);

      send(WK, P1, 1'b0, 64'd0, 1'b0);  receive("weak_1", 1'b1, r);
      send(WK, r, 1'b0, P1, 1'b1);      receive("weak_2", 1'b1, r);

      send(K1 ^ PAR, P1, 1'b0, C1, 1'b1);  receive("par_enc", 1'b1, r);
      send(K1 ^ PAR, C1, 1'b1, P1, 1'b1);  receive("par_dec", 1'b1, r);
      send(64'd0 ^ PAR, 64'd0, 1'b0, CZ, 1'b1);  receive("par_zero", 1'b1, r);

      // Backpressure: result must hold while a second request waits.
      send(K1, P1, 1'b0, C1, 1'b1);
      n = 0;
      while (!out_valid && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      chk_eq("bp_latency", 64'(n), 64'd16);
      in_key     = 64'd0;
      in_data    = 64'd0;
      in_decrypt = 1'b0;
      in_valid   = 1'b1;
      held = exp_q.pop_front();
      void'(chk_q.pop_front());
      repeat (10) begin
         chk_eq("bp_data", out_data, held);
         chk_eq("bp_in_ready", 64'(in_ready), 64'd0);
         chk_eq("bp_out_valid", 64'(out_valid), 64'd1);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk_eq("bp_idle", 64'(in_ready), 64'd1);
      chk_eq("bp_released", 64'(out_valid), 64'd0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk_eq("bp_accepted", 64'(in_ready), 64'd0);
      exp_q.push_back(CZ);
      chk_q.push_back(1'b1);
      receive("bp_second", 1'b1, r);

      // Request inputs wiggle during RUN; the block in flight must not notice.
      send(K1, P1, 1'b0, C1, 1'b1);
      repeat (10) begin
         in_key     = {$urandom, $urandom};
         in_data    = {$urandom, $urandom};
         in_decrypt = ~in_decrypt;
         @(posedge clk); #1;
      end
      receive("midrun", 1'b0, r);

      // Reset during round 7 discards the block.
      send(K1, C1, 1'b1, P1, 1'b1);
      void'(exp_q.pop_back());
      void'(chk_q.pop_back());
      repeat (6) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk_eq("rst_mid_out_valid", 64'(out_valid), 64'd0);
      chk_eq("rst_mid_in_ready", 64'(in_ready), 64'd1);
      chk_eq("rst_mid_out_data", out_data, 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      send(K1, P1, 1'b0, C1, 1'b1);  receive("post_rst", 1'b1, r);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
